// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with wrap/saturate boundaries, synchronous load and terminal-count pulse.
// Optional built-in prescaler enabled by defining the macro UDC_PRESCALE_EN.
module param_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9,
  parameter int DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ud,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  if (WIDTH < 2 || WIDTH > 16 || MAX < 1 || MAX > (2 ** WIDTH) - 1 || DIV < 2) begin : g_param_check
    $error("param_updown_counter: illegal WIDTH/MAX/DIV combination");
  end

  logic step_cycle;

`ifdef UDC_PRESCALE_EN
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

  logic [PW-1:0] psc;

  // Prescaler advances only on enabled cycles and is never disturbed by load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (en) begin
      psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
    end
  end

  assign step_cycle = en && (psc == PSC_LAST);
`else
  assign step_cycle = en;
`endif

  logic [WIDTH-1:0] next_count;
  logic             next_tc;

  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    if (load) begin
      next_count = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step_cycle) begin
      if (ud) begin
        if (count == MAX_V) begin
          next_count = sat ? MAX_V : '0;
          next_tc    = 1'b1;
        end else begin
          next_count = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          next_count = sat ? '0 : MAX_V;
          next_tc    = 1'b1;
        end else begin
          next_count = count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      step  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      count <= next_count;
      step  <= step_cycle;
      tc    <= next_tc;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: expected (count, tc) pairs are queued per step
// and a monitor pops one whenever the DUT raises step.
module tb_param_updown_counter;

  localparam int WIDTH = 4;
  localparam int MAX   = 9;
  localparam int DIV   = 4;
`ifdef UDC_PRESCALE_EN
  localparam int DIV_EFF = DIV;
`else
  localparam int DIV_EFF = 1;
`endif
  localparam int PARTIAL = DIV_EFF / 2;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             en       = 1'b0;
  logic             ud       = 1'b0;
  logic             sat      = 1'b0;
  logic             load     = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             tc;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             tc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   checks = 0;
  int   errors = 0;

  param_updown_counter #(.WIDTH(WIDTH), .MAX(MAX), .DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ud       (ud),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .step     (step),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic u, input logic s, input logic l,
                               input logic [WIDTH-1:0] lv, input int cycles);
    en       = e;
    ud       = u;
    sat      = s;
    load     = l;
    load_val = lv;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectStep(input logic [WIDTH-1:0] c, input logic t);
    exp_q.push_back({c, t});
  endtask

  task automatic runSteps(input logic u, input logic s, input int n);
    applyStimulus(1'b1, u, s, 1'b0, '0, n * DIV_EFF);
  endtask

  // Counts enabled cycles until the first step pulse, bounded so a dead DUT cannot hang the run.
  task automatic measureStep(input string name, input int expected);
    int cycles = 0;
    bit found  = 0;
    en   = 1'b1;
    load = 1'b0;
    while (!found && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
      if (step) found = 1;
    end
    en = 1'b0;
    checkOutput(name, found ? cycles : -1, expected);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (step) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_step", step, 0);
          end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("step_count", count, mon_exp.count);
            checkOutput("step_tc", tc, mon_exp.tc);
          end
        end else begin
          checkOutput("idle_tc", tc, 0);
        end
      end
    end
  end

  initial begin
    #1;
    checkOutput("reset_count", count, 0);
    checkOutput("reset_step", step, 0);
    checkOutput("reset_tc", tc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Up count with wrap from reset: 1..9 then 0 with tc.
    for (int i = 1; i <= 9; i++) expectStep(i[WIDTH-1:0], 1'b0);
    expectStep(4'd0, 1'b1);
    runSteps(1'b1, 1'b0, 10);

    // Down saturate at 0: holds and pulses tc every step.
    repeat (3) expectStep(4'd0, 1'b1);
    runSteps(1'b0, 1'b1, 3);

    // Load 13 on a step cycle clamps to 9 without tc; next up step wraps.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, DIV_EFF - 1);
    expectStep(4'd9, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 1);
    checkOutput("load_clamp_count", count, 9);
    checkOutput("load_clamp_tc", tc, 0);
    expectStep(4'd0, 1'b1);
    runSteps(1'b1, 1'b0, 1);

    // Pause mid-prescale with a load while disabled, then resume.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, PARTIAL);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1);
    checkOutput("load_disabled_count", count, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 10);
    checkOutput("hold_count", count, 5);
    checkOutput("hold_step", step, 0);
    checkOutput("hold_tc", tc, 0);
    expectStep(4'd6, 1'b0);
    measureStep("resume_latency", DIV_EFF - PARTIAL);

    // Asynchronous reset mid-prescale at count 7.
    expectStep(4'd7, 1'b0);
    runSteps(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, PARTIAL);
    @(negedge clk);
    #1;
    checkOutput("pre_reset_count", count, 7);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_count", count, 0);
    checkOutput("async_reset_step", step, 0);
    checkOutput("async_reset_tc", tc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ud    = 1'b1;
    sat   = 1'b0;
    expectStep(4'd1, 1'b0);
    measureStep("post_reset_latency", DIV_EFF);

    // Down count with wrap from 0: 9 (tc), 8, 7.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1);
    checkOutput("load_zero_count", count, 0);
    expectStep(4'd9, 1'b1);
    expectStep(4'd8, 1'b0);
    expectStep(4'd7, 1'b0);
    runSteps(1'b0, 1'b0, 3);

    // Up saturate at MAX, then mode and direction changes between steps.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 1);
    checkOutput("load_12_clamp", count, 9);
    expectStep(4'd9, 1'b1);
    expectStep(4'd9, 1'b1);
    runSteps(1'b1, 1'b1, 2);
    expectStep(4'd0, 1'b1);
    runSteps(1'b1, 1'b0, 1);
    expectStep(4'd9, 1'b1);
    runSteps(1'b0, 1'b0, 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 3);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
